// File: rtl/osd_scanlines.sv
// CRT scanline stage after the OSD overlay. It darkens every odd active line, detects the
// hs/vs polarity by itself, and has a fixed 2-clock latency on data and syncs.
module osd_scanlines #(
    parameter int HCNT_W = 12,
    parameter int VCNT_W = 11
) (
    input  logic        clk_video,
    input  logic        reset_n,
    input  logic [1:0]  mode,
    input  logic [23:0] din,
    input  logic        de_in,
    input  logic        hs_in,
    input  logic        vs_in,
    output logic [23:0] dout,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        hs_pol,
    output logic        vs_pol
);

    typedef enum logic [1:0] {
        SL_OFF = 2'd0,
        SL_25  = 2'd1,
        SL_50  = 2'd2,
        SL_75  = 2'd3
    } strength_e;

    // Reset asserts asynchronously and releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic              hs_d1_q, vs_d1_q;
    logic              hs_edge, hs_fall, hs_lead;
    logic              vs_edge, vs_fall, vs_lead;
    logic [HCNT_W-1:0] hrun_q, hrun_d, hhi_q, hhi_d, hlo_q, hlo_d;
    logic [VCNT_W-1:0] vrun_q, vrun_d, vhi_q, vhi_d, vlo_q, vlo_d;
    logic              hs_pol_q, hs_pol_d, vs_pol_q, vs_pol_d;
    logic              parity_q, parity_d;
    strength_e         mode_q, mode_d;

    assign hs_edge = hs_in ^ hs_d1_q;
    assign hs_fall = hs_d1_q & ~hs_in;
    assign hs_lead = hs_edge & (hs_in == hs_pol_q);
    assign vs_edge = vs_in ^ vs_d1_q;
    assign vs_fall = vs_d1_q & ~vs_in;
    assign vs_lead = vs_edge & (vs_in == vs_pol_q);

    // The shorter level of hs is its active level. Equal runs, including two saturated runs, keep the old value.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        hrun_d   = hrun_q;
        hhi_d    = hhi_q;
        hlo_d    = hlo_q;
        hs_pol_d = hs_pol_q;
        if (hs_edge) begin
            hrun_d = '0;
            if (hs_d1_q) hhi_d = hrun_q;
            else         hlo_d = hrun_q;
        end else if (hrun_q != '1) begin
            hrun_d = hrun_q + HCNT_W'(1);
        end
        if (hs_fall && (hhi_d != hlo_d)) begin
            hs_pol_d = (hhi_d < hlo_d);
        end
    end

    // vs uses the same scheme. Its run length is counted in hs leading edges (lines).
    always_comb begin
        vrun_d   = vrun_q;
        vhi_d    = vhi_q;
        vlo_d    = vlo_q;
        vs_pol_d = vs_pol_q;
        if (vs_edge) begin
            vrun_d = '0;
            if (vs_d1_q) vhi_d = vrun_q;
            else         vlo_d = vrun_q;
        end else if (hs_lead && (vrun_q != '1)) begin
            vrun_d = vrun_q + VCNT_W'(1);
        end
        if (vs_fall && (vhi_d != vlo_d)) begin
            vs_pol_d = (vhi_d < vlo_d);
        end
    end

    // A frame start clears the parity even when the line starts on the same clock.
    // The strength changes only at a frame boundary.
    always_comb begin
        parity_d = parity_q;
        mode_d   = mode_q;
        if (vs_lead) begin
            parity_d = 1'b0;
            mode_d   = strength_e'(mode);
        end else if (hs_lead) begin
            parity_d = ~parity_q;
        end
    end

    always_ff @(posedge clk_video or negedge rst_n) begin
        if (!rst_n) begin
            hs_d1_q  <= 1'b0;
            vs_d1_q  <= 1'b0;
            hrun_q   <= '0;
            hhi_q    <= '0;
            hlo_q    <= '0;
            vrun_q   <= '0;
            vhi_q    <= '0;
            vlo_q    <= '0;
            hs_pol_q <= 1'b0;
            vs_pol_q <= 1'b0;
            parity_q <= 1'b0;
            mode_q   <= SL_OFF;
        end else begin
            hs_d1_q  <= hs_in;
            vs_d1_q  <= vs_in;
            hrun_q   <= hrun_d;
            hhi_q    <= hhi_d;
            hlo_q    <= hlo_d;
            vrun_q   <= vrun_d;
            vhi_q    <= vhi_d;
            vlo_q    <= vlo_d;
            hs_pol_q <= hs_pol_d;
            vs_pol_q <= vs_pol_d;
            parity_q <= parity_d;
            mode_q   <= mode_d;
        end
    end

    // Stage 1 computes the candidate levels for each 8-bit channel. c>>1 + c>>2 cannot overflow 8 bits.
    logic [23:0] half_d, quart_d, three_d;

    always_comb begin
        half_d  = '0;
        quart_d = '0;
        three_d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            half_d[ch*8 +: 8]  = din[ch*8 +: 8] >> 1;
            quart_d[ch*8 +: 8] = din[ch*8 +: 8] >> 2;
            three_d[ch*8 +: 8] = (din[ch*8 +: 8] >> 1) + (din[ch*8 +: 8] >> 2);
        end
    end

    logic [23:0] pix_s1_q, half_s1_q, quart_s1_q, three_s1_q;
    logic        de_s1_q, hs_s1_q, vs_s1_q, par_s1_q;

    always_ff @(posedge clk_video or negedge rst_n) begin
        if (!rst_n) begin
            pix_s1_q   <= '0;
            half_s1_q  <= '0;
            quart_s1_q <= '0;
            three_s1_q <= '0;
            de_s1_q    <= 1'b0;
            hs_s1_q    <= 1'b0;
            vs_s1_q    <= 1'b0;
            par_s1_q   <= 1'b0;
        end else begin
            pix_s1_q   <= din;
            half_s1_q  <= half_d;
            quart_s1_q <= quart_d;
            three_s1_q <= three_d;
            de_s1_q    <= de_in;
            hs_s1_q    <= hs_in;
            vs_s1_q    <= vs_in;
            par_s1_q   <= parity_q;
        end
    end

    // Stage 2 selects the output. Blanking and even lines pass through unchanged.
    logic [23:0] dout_d;

    always_comb begin
        dout_d = pix_s1_q;
        if (de_s1_q && par_s1_q) begin
            case (mode_q)
                SL_25:   dout_d = three_s1_q;
                SL_50:   dout_d = half_s1_q;
                SL_75:   dout_d = quart_s1_q;
                default: dout_d = pix_s1_q;
            endcase
        end
    end

    logic [23:0] dout_q;
    logic        de_q, hs_q, vs_q;

    always_ff @(posedge clk_video or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
            de_q   <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
        end else begin
            dout_q <= dout_d;
            de_q   <= de_s1_q;
            hs_q   <= hs_s1_q;
            vs_q   <= vs_s1_q;
        end
    end

    assign dout   = dout_q;
    assign de_out = de_q;
    assign hs_out = hs_q;
    assign vs_out = vs_q;
    assign hs_pol = hs_pol_q;
    assign vs_pol = vs_pol_q;

endmodule

// File: tb/tb_osd_scanlines.sv
// Directed bench for osd_scanlines: pipeline delay, polarity detection, parity, mode latch and reset.
module tb_osd_scanlines;

    localparam int HS_LO  = 96;
    localparam int LINE_A = 800;
    localparam int HS_HI  = 40;
    localparam int LINE_B = 1040;

    logic        clk_video = 1'b0;
    logic        reset_n   = 1'b1;
    logic [1:0]  mode;
    logic [23:0] din;
    logic        de_in, hs_in, vs_in;
    logic [23:0] dout;
    logic        de_out, hs_out, vs_out, hs_pol, vs_pol;

    int checks = 0;
    int errors = 0;

    always #5 clk_video = ~clk_video;

    osd_scanlines #(.HCNT_W(12), .VCNT_W(11)) dut (
        .clk_video (clk_video),
        .reset_n   (reset_n),
        .mode      (mode),
        .din       (din),
        .de_in     (de_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .dout      (dout),
        .de_out    (de_out),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .hs_pol    (hs_pol),
        .vs_pol    (vs_pol)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk_video);
        #1;
    endtask

    task automatic idle(input int n, input logic hs_v, input logic vs_v);
        for (int i = 0; i < n; i++) begin
            hs_in = hs_v;
            vs_in = vs_v;
            de_in = 1'b0;
            din   = 24'h0;
            tick();
        end
    endtask

    task automatic apply_reset(input logic hs_v, input logic vs_v);
        reset_n = 1'b0;
        idle(3, hs_v, vs_v);
        reset_n = 1'b1;
        idle(6, hs_v, vs_v);
    endtask

    // One video line: sync first, then the opposite level. de is high inside a window after the sync.
    // After each tick the outputs show the input driven one iteration earlier.
    task automatic send_line(input int sync_len, input int line_len, input logic hs_act,
                             input logic vs_val, input logic [23:0] pix,
                             input logic [23:0] exp_px, input string name);
        logic       vs_prev;
        logic [5:0] sync_seen;
        logic [5:0] sync_exp;
        vs_prev   = vs_in;
        sync_seen = '0;
        sync_exp  = {~hs_act, hs_act, hs_act, ~hs_act, vs_prev, vs_val};
        for (int i = 0; i < line_len; i++) begin
            hs_in = (i < sync_len) ? hs_act : ~hs_act;
            vs_in = vs_val;
            de_in = (i >= sync_len + 8) && (i < line_len - 8);
            din   = de_in ? pix : 24'h0;
            tick();
            if (i == 0) begin
                sync_seen[5] = hs_out;
                sync_seen[1] = vs_out;
            end
            if (i == 1) begin
                sync_seen[4] = hs_out;
                sync_seen[0] = vs_out;
            end
            if (i == sync_len)     sync_seen[3] = hs_out;
            if (i == sync_len + 1) sync_seen[2] = hs_out;
            if (i == sync_len / 2) begin
                checks++;
                if (dout !== 24'h0 || de_out !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_blank: dout=%h de_out=%b, expected dout=000000 de_out=0",
                             name, dout, de_out);
                end
            end
            if (i == sync_len + 64) begin
                checks++;
                if (dout !== exp_px || de_out !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_pix: dout=%h de_out=%b, expected dout=%h de_out=1",
                             name, dout, de_out, exp_px);
                end
            end
        end
        checks++;
        if (sync_seen !== sync_exp) begin
            errors++;
            $display("FAIL %s_sync_delay: seen=%b, expected=%b", name, sync_seen, sync_exp);
        end
    endtask

    task automatic test_reset();
        mode  = 2'd2;
        hs_in = 1'b1;
        vs_in = 1'b1;
        de_in = 1'b1;
        din   = 24'hFFFFFF;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({dout, de_out, hs_out, vs_out} !== 27'h0) begin
            errors++;
            $display("FAIL reset_outputs: dout=%h de=%b hs=%b vs=%b, expected all 0",
                     dout, de_out, hs_out, vs_out);
        end
        tick();
        tick();
        checks++;
        if ({dout, de_out, hs_out, vs_out} !== 27'h0) begin
            errors++;
            $display("FAIL reset_held: dout=%h de=%b hs=%b vs=%b, expected all 0",
                     dout, de_out, hs_out, vs_out);
        end
        checks++;
        if ({hs_pol, vs_pol} !== 2'b00) begin
            errors++;
            $display("FAIL reset_pol: hs_pol=%b vs_pol=%b, expected 0 0", hs_pol, vs_pol);
        end
        reset_n = 1'b1;
        idle(6, 1'b1, 1'b1);
    endtask

    task automatic test_mode2_active_low();
        mode = 2'd2;
        apply_reset(1'b1, 1'b1);
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'hFF8040, 24'hFF8040, "A_L0_premode");
        checks++;
        if (hs_pol !== 1'b0) begin
            errors++;
            $display("FAIL A_hs_pol: hs_pol=%b, expected 0", hs_pol);
        end
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'hFF8040, 24'hFF8040, "A_L1_even");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'hFF8040, 24'h7F4020, "A_L2_odd");
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'hFF8040, 24'hFF8040, "A_L3_even");
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'hFF8040, 24'h7F4020, "A_L4_odd");
        checks++;
        if (hs_pol !== 1'b0 || vs_pol !== 1'b0) begin
            errors++;
            $display("FAIL A_pol_end: hs_pol=%b vs_pol=%b, expected 0 0", hs_pol, vs_pol);
        end
    endtask

    task automatic test_hs_active_high();
        mode = 2'd2;
        apply_reset(1'b0, 1'b1);
        idle(1100, 1'b0, 1'b1);
        send_line(HS_HI, LINE_B, 1'b1, 1'b1, 24'hFF8040, 24'hFF8040, "B_L0");
        send_line(HS_HI, LINE_B, 1'b1, 1'b1, 24'hFF8040, 24'hFF8040, "B_L1");
        checks++;
        if (hs_pol !== 1'b1) begin
            errors++;
            $display("FAIL B_hs_pol: hs_pol=%b, expected 1", hs_pol);
        end
        send_line(HS_HI, LINE_B, 1'b1, 1'b0, 24'hFF8040, 24'hFF8040, "B_L2_even");
        send_line(HS_HI, LINE_B, 1'b1, 1'b0, 24'hFF8040, 24'h7F4020, "B_L3_odd");
        send_line(HS_HI, LINE_B, 1'b1, 1'b1, 24'hFF8040, 24'hFF8040, "B_L4_even");
        send_line(HS_HI, LINE_B, 1'b1, 1'b1, 24'hFF8040, 24'h7F4020, "B_L5_odd");
    endtask

    task automatic test_mode1_mode3();
        mode = 2'd1;
        apply_reset(1'b1, 1'b1);
        checks++;
        if (hs_pol !== 1'b0) begin
            errors++;
            $display("FAIL C_hs_pol_after_reset: hs_pol=%b, expected 0", hs_pol);
        end
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'h804001, 24'h804001, "C_L0");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'h804001, 24'h804001, "C_L1");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'h804001, 24'h603000, "C_L2_m1");
        mode = 2'd3;
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'h804001, 24'h804001, "C_L3");
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'h804001, 24'h603000, "C_L4_still_m1");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'h804001, 24'h804001, "C_L5");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'h804001, 24'h201000, "C_L6_m3");
    endtask

    task automatic test_midframe_mode_change();
        mode = 2'd0;
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'hFF8040, 24'hFF8040, "D_L7");
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'hFF8040, 24'h3F2010, "D_L8_old_m3");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'hFF8040, 24'hFF8040, "D_L9");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'hFF8040, 24'hFF8040, "D_L10_off");
        mode = 2'd3;
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'hFF8040, 24'hFF8040, "D_L11");
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'hFF8040, 24'hFF8040, "D_L12_ignored");
    endtask

    task automatic test_same_clock_leads();
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'hFF8040, 24'hFF8040, "E_L13");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'hFF8040, 24'hFF8040, "E_L14_vs_wins");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'hFF8040, 24'h3F2010, "E_L15_first_odd");
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'hFF8040, 24'hFF8040, "E_L16");
    endtask

    task automatic test_reset_midline();
        for (int i = 0; i < 200; i++) begin
            hs_in = (i < HS_LO) ? 1'b0 : 1'b1;
            vs_in = 1'b1;
            de_in = (i >= HS_LO + 8);
            din   = de_in ? 24'hFF8040 : 24'h0;
            tick();
        end
        checks++;
        if (dout !== 24'h3F2010 || de_out !== 1'b1) begin
            errors++;
            $display("FAIL R_before: dout=%h de_out=%b, expected dout=3f2010 de_out=1", dout, de_out);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({dout, de_out, hs_out, vs_out} !== 27'h0) begin
            errors++;
            $display("FAIL R_async: dout=%h de=%b hs=%b vs=%b, expected all 0",
                     dout, de_out, hs_out, vs_out);
        end
        idle(3, 1'b1, 1'b1);
        reset_n = 1'b1;
        idle(6, 1'b1, 1'b1);
        checks++;
        if ({hs_pol, vs_pol} !== 2'b00) begin
            errors++;
            $display("FAIL R_pol: hs_pol=%b vs_pol=%b, expected 0 0", hs_pol, vs_pol);
        end
        send_line(HS_LO, LINE_A, 1'b0, 1'b1, 24'hFF8040, 24'hFF8040, "R_L0_passthru");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'hFF8040, 24'hFF8040, "R_L1");
        send_line(HS_LO, LINE_A, 1'b0, 1'b0, 24'hFF8040, 24'h3F2010, "R_L2_m3");
    endtask

    initial begin
        mode  = 2'd0;
        din   = 24'h0;
        de_in = 1'b0;
        hs_in = 1'b1;
        vs_in = 1'b1;
        #2;
        test_reset();
        test_mode2_active_low();
        test_hs_active_high();
        test_mode1_mode3();
        test_midframe_mode_change();
        test_same_clock_leads();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
